// File: rtl/bus_arbiter_pkg.sv
// Shared types and the round-robin search used by the bus arbiter.
// Pure combinational helpers; no state, no handshake.
package bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit at or after last_owner+1 (mod n), searching upward with wrap.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_N-1:0] vec,
        input logic [RR_IDX_W-1:0] last_owner,
        input int                  n
    );
        rr_pick_t res;
        int       cand;
        res  = '0;
        cand = 0;
        for (int i = RR_MAX_N; i >= 1; i--) begin
            if (i <= n) begin
                cand = (int'(last_owner) + i) % n;
                if (vec[cand[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = cand[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_arbiter_decoder.sv
// Binary index to one-hot vector, gated by an enable; combinational.
// No handshake; output follows inputs in the same cycle.
module bus_arbiter_decoder #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0]    idx,
    input  logic               en,
    output logic [2**SIZE-1:0] onehot
);

    localparam int N = 2**SIZE;

    assign onehot = en ? (N'(1) << idx) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter with bounded hold: registered one-hot grant plus owner index.
// Latency 1 cycle from request to grant; no backpressure, requesters hold req until done.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int SIZE     = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2**SIZE-1:0]  req,
    output logic [2**SIZE-1:0]  grant,
    output logic [SIZE-1:0]     grant_idx,
    output logic                grant_valid,
    output logic                switch_pulse
);

    localparam int N  = 2**SIZE;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_t      state_q, state_d;
    logic [SIZE-1:0] grant_idx_q, grant_idx_d;
    logic            grant_valid_q, grant_valid_d;
    logic            switch_pulse_q, switch_pulse_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SIZE-1:0] last_owner_q, last_owner_d;

    rr_pick_t        pick_any, pick_other;
    logic            any_ok, other_ok;
    logic            take;
    logic [SIZE-1:0] take_idx;

    assign pick_any   = rr_pick(RR_MAX_N'(req), RR_IDX_W'(last_owner_q), N);
    assign pick_other = rr_pick(RR_MAX_N'(req & ~grant), RR_IDX_W'(last_owner_q), N);
    assign any_ok     = pick_any.found && (int'(pick_any.idx) < N);
    assign other_ok   = pick_other.found && (int'(pick_other.idx) < N);

    // Next-state and handoff selection.
    always_comb begin
        state_d        = state_q;
        grant_idx_d    = grant_idx_q;
        grant_valid_d  = grant_valid_q;
        hold_cnt_d     = hold_cnt_q;
        last_owner_d   = last_owner_q;
        take           = 1'b0;
        take_idx       = grant_idx_q;

        case (state_q)
            ARB_IDLE: begin
                if (any_ok) begin
                    take     = 1'b1;
                    take_idx = pick_any.idx[SIZE-1:0];
                end
            end
            ARB_GRANT: begin
                if (!req[grant_idx_q]) begin
                    if (any_ok) begin
                        take     = 1'b1;
                        take_idx = pick_any.idx[SIZE-1:0];
                    end else begin
                        state_d       = ARB_IDLE;
                        grant_valid_d = 1'b0;
                        hold_cnt_d    = '0;
                    end
                end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_MAX && other_ok) begin
                    take     = 1'b1;
                    take_idx = pick_other.idx[SIZE-1:0];
                end else if (MAX_HOLD != 0 && hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (take) begin
            state_d       = ARB_GRANT;
            grant_valid_d = 1'b1;
            grant_idx_d   = take_idx;
            last_owner_d  = take_idx;
            hold_cnt_d    = HW'(1);
        end
    end

    always_comb begin
        switch_pulse_d = take;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ARB_IDLE;
            grant_idx_q    <= '0;
            grant_valid_q  <= 1'b0;
            switch_pulse_q <= 1'b0;
            hold_cnt_q     <= '0;
            last_owner_q   <= SIZE'(N - 1);
        end else begin
            state_q        <= state_d;
            grant_idx_q    <= grant_idx_d;
            grant_valid_q  <= grant_valid_d;
            switch_pulse_q <= switch_pulse_d;
            hold_cnt_q     <= hold_cnt_d;
            last_owner_q   <= last_owner_d;
        end
    end

    assign grant_idx    = grant_idx_q;
    assign grant_valid  = grant_valid_q;
    assign switch_pulse = switch_pulse_q;

    bus_arbiter_decoder #(.SIZE(SIZE)) u_dec (
        .idx    (grant_idx_q),
        .en     (grant_valid_q),
        .onehot (grant)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a reference model.
// Two instances run side by side: MAX_HOLD=4 and MAX_HOLD=0.
module tb_bus_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, req0;
    logic [3:0] grant, grant0;
    logic [1:0] grant_idx, grant_idx0;
    logic       grant_valid, grant_valid0;
    logic       switch_pulse, switch_pulse0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.SIZE(2), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .grant_idx(grant_idx),
        .grant_valid(grant_valid), .switch_pulse(switch_pulse)
    );

    bus_arbiter #(.SIZE(2), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .grant(grant0), .grant_idx(grant_idx0),
        .grant_valid(grant_valid0), .switch_pulse(switch_pulse0)
    );

    // Reference model: who owns the bus, how long, and the rotation pointer.
    bit m_valid[2];
    int m_idx[2];
    int m_last[2];
    int m_hold[2];
    bit m_pulse[2];
    int mh[2] = '{4, 0};

    function automatic int rr_next(input logic [3:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_give(input int k, input int who);
        m_valid[k] = 1'b1;
        m_idx[k]   = who;
        m_last[k]  = who;
        m_hold[k]  = 1;
        m_pulse[k] = 1'b1;
    endtask

    task automatic model_step(input int k, input logic [3:0] r, input logic rst);
        logic [3:0] others;
        if (rst) begin
            m_valid[k] = 1'b0; m_idx[k] = 0; m_last[k] = N - 1; m_hold[k] = 0; m_pulse[k] = 1'b0;
            return;
        end
        m_pulse[k] = 1'b0;
        if (!m_valid[k]) begin
            if (r != 0) model_give(k, rr_next(r, m_last[k]));
        end else if (!r[m_idx[k]]) begin
            if (r != 0) model_give(k, rr_next(r, m_last[k]));
            else begin m_valid[k] = 1'b0; m_hold[k] = 0; end
        end else begin
            others = r & ~(4'b0001 << m_idx[k]);
            if (mh[k] != 0 && m_hold[k] == mh[k] && others != 0)
                model_give(k, rr_next(others, m_last[k]));
            else if (m_hold[k] < mh[k])
                m_hold[k]++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        logic [3:0] eg0, eg1;
        eg0 = m_valid[0] ? (4'b0001 << m_idx[0]) : 4'b0000;
        eg1 = m_valid[1] ? (4'b0001 << m_idx[1]) : 4'b0000;
        chk({tag, ".h4.grant"}, 32'(grant), 32'(eg0));
        chk({tag, ".h4.valid"}, 32'(grant_valid), 32'(m_valid[0]));
        chk({tag, ".h4.pulse"}, 32'(switch_pulse), 32'(m_pulse[0]));
        if (m_valid[0]) chk({tag, ".h4.idx"}, 32'(grant_idx), m_idx[0]);
        chk({tag, ".h0.grant"}, 32'(grant0), 32'(eg1));
        chk({tag, ".h0.valid"}, 32'(grant_valid0), 32'(m_valid[1]));
        chk({tag, ".h0.pulse"}, 32'(switch_pulse0), 32'(m_pulse[1]));
        if (m_valid[1]) chk({tag, ".h0.idx"}, 32'(grant_idx0), m_idx[1]);
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] r0, input logic rst);
        req   = r;
        req0  = r0;
        reset = rst;
        @(posedge clk);
        model_step(0, r, rst);
        model_step(1, r0, rst);
        #1;
        cmp_model(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [3:0] rr, rr0;

        // Reset values
        step("rst", 4'b0000, 4'b0000, 1'b1);
        step("rst", 4'b0000, 4'b0000, 1'b1);
        chk("rst.grant", 32'(grant), 0);
        chk("rst.idx", 32'(grant_idx), 0);
        chk("rst.valid", 32'(grant_valid), 0);
        chk("rst.pulse", 32'(switch_pulse), 0);

        // Idle with no requests
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step("idle", 4'b0000, 4'b0000, 1'b0);
            pulses += int'(switch_pulse);
        end
        chk("idle.pulses", pulses, 0);

        // Basic grant then release handoff without idle cycle
        step("rst", 4'b0000, 4'b0000, 1'b1);
        step("hand", 4'b1010, 4'b0000, 1'b0);
        chk("hand.c1.grant", 32'(grant), 32'h2);
        chk("hand.c1.idx", 32'(grant_idx), 1);
        chk("hand.c1.pulse", 32'(switch_pulse), 1);
        step("hand", 4'b1010, 4'b0000, 1'b0);
        step("hand", 4'b1010, 4'b0000, 1'b0);
        chk("hand.c3.pulse", 32'(switch_pulse), 0);
        step("hand", 4'b1000, 4'b0000, 1'b0);
        chk("hand.c4.grant", 32'(grant), 32'h8);
        chk("hand.c4.idx", 32'(grant_idx), 3);
        chk("hand.c4.valid", 32'(grant_valid), 1);
        chk("hand.c4.pulse", 32'(switch_pulse), 1);

        // Full contention: rotation with 4-cycle slots
        step("rst", 4'b0000, 4'b0000, 1'b1);
        for (int c = 1; c <= 21; c++) begin
            step("rot", 4'b1111, 4'b0000, 1'b0);
            chk("rot.idx", 32'(grant_idx), ((c - 1) / 4) % 4);
            chk("rot.pulse", 32'(switch_pulse), 32'(((c - 1) % 4) == 0));
        end

        // Sole requester keeps the grant, counter saturates
        step("rst", 4'b0000, 4'b0000, 1'b1);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step("solo", 4'b0100, 4'b0000, 1'b0);
            chk("solo.grant", 32'(grant), 32'h4);
            pulses += int'(switch_pulse);
        end
        chk("solo.pulses", pulses, 1);
        chk("solo.hold_cnt", 32'(dut.hold_cnt_q), 4);

        // Reset in the middle of a grant
        step("rst", 4'b0000, 4'b0000, 1'b1);
        step("mid", 4'b0001, 4'b0000, 1'b0);
        chk("mid.c1.grant", 32'(grant), 32'h1);
        step("mid", 4'b0001, 4'b0000, 1'b0);
        step("mid", 4'b0001, 4'b0000, 1'b1);
        chk("mid.rst.grant", 32'(grant), 0);
        chk("mid.rst.valid", 32'(grant_valid), 0);
        chk("mid.rst.pulse", 32'(switch_pulse), 0);
        step("mid", 4'b1001, 4'b0000, 1'b0);
        chk("mid.after.idx", 32'(grant_idx), 0);
        chk("mid.after.pulse", 32'(switch_pulse), 1);

        // Timeout disabled instance
        step("rst", 4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step("nohold", 4'b0000, 4'b0011, 1'b0);
            chk("nohold.grant", 32'(grant0), 32'h1);
        end
        step("nohold", 4'b0000, 4'b0010, 1'b0);
        chk("nohold.drop.grant", 32'(grant0), 32'h2);
        chk("nohold.drop.pulse", 32'(switch_pulse0), 1);

        // Randomized traffic with occasional resets
        step("rst", 4'b0000, 4'b0000, 1'b1);
        rr  = 4'b0000;
        rr0 = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) rr[b]  = ~rr[b];
                if ($urandom_range(0, 5) == 0) rr0[b] = ~rr0[b];
            end
            step("rand", rr, rr0, ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing one resource (e.g. unified memory port) among 2**SIZE requesters; issues a registered one-hot grant plus a binary owner index.
- Sits between the requesters (fetch, load/store, DMA-style masters) and the shared bus mux; the bus mux selects on grant_idx.
- Bounded hold time prevents starvation; handoff to a waiting requester has no dead cycle.

Parameters:
- SIZE, 2, number of index bits; requester count N = 2**SIZE.
- MAX_HOLD, 16, max consecutive grant cycles per owner while others wait; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  N  request vector; requester holds bit high for the whole transaction
- grant  output  N  one-hot grant, all zero when idle
- grant_idx  output  SIZE  binary index of current owner, valid when grant_valid
- grant_valid  output  1  any grant active
- switch_pulse  output  1  one-cycle pulse on the first cycle of every new grant

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: grant=0, grant_idx=0, grant_valid=0, switch_pulse=0, state=ARB_IDLE, hold_cnt=0, last_owner=N-1 (index 0 has top priority after reset). Reset wins over every other event.
- All outputs registered; grant = one-hot of grant_idx, gated by grant_valid.
- Round-robin pick: search from (last_owner+1) mod N upward, wrapping, and take the first set bit of the candidate vector. last_owner updates on every new grant.
- ARB_IDLE: if req != 0, pick from req; next cycle state=ARB_GRANT, grant_valid=1, hold_cnt=1, switch_pulse=1. Grant latency is 1 cycle from req sampled high. If req == 0, stay in ARB_IDLE.
- ARB_GRANT, evaluated each edge (owner = grant_idx):
  - Release: req[owner]==0. If other requests are pending, pick from req and grant next cycle (no idle cycle, switch_pulse=1, hold_cnt=1). Otherwise go to ARB_IDLE with grant=0 next cycle.
  - Timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD, and (req & ~grant)!=0. Pick from req & ~grant and switch next cycle, even though the owner still requests. The preempted owner re-enters round-robin normally.
  - Timeout with no other request: owner keeps the grant; hold_cnt saturates at MAX_HOLD.
  - Otherwise: hold the grant; hold_cnt increments, saturating at MAX_HOLD.
- The owner therefore holds the grant for at most MAX_HOLD consecutive cycles while contention exists.
- switch_pulse is 0 on every cycle that is not the first cycle of a grant, including the transition to idle.
- The same requester can be re-granted only after passing through the search order. It can follow itself directly only when it is the sole requester.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1.
- Reset mid-grant: grant drops on the next edge; no pulse; priority pointer returns to the reset value.

Decomposition:
- Package bus_arbiter_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}
  - rr_pick function (vector, last_owner) returning index plus found flag
- Sub-module: the existing Decoder (SIZE) converts grant_idx to the one-hot grant, ANDed with grant_valid.
- The binary-to-one-hot conversion is not duplicated in arbiter logic.

Test Plan (SIZE=2, MAX_HOLD=4 unless stated):
- Reset, then req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, switch_pulse never asserts.
- After reset, req=4'b1010 at cycle 0 -> cycle 1: grant=4'b0010, grant_idx=1, switch_pulse=1. Drop req[1] at cycle 3 -> cycle 4: grant=4'b1000, grant_idx=3, no idle cycle.
- req=4'b1111 held constant -> grants rotate 0,1,2,3,0, each exactly 4 cycles; switch_pulse every 4th cycle.
- Only req[2] held for 20 cycles -> grant=4'b0100 continuous, single switch_pulse, hold_cnt saturates at 4.
- Owner 0 granted, req=4'b0001; at cycle 2 of its grant assert reset -> next edge: grant=0, grant_valid=0. After reset release with req=4'b1001 -> index 0 granted first.
- MAX_HOLD=0, req=4'b0011 held -> owner 0 keeps the grant indefinitely. Drop req[0] -> next cycle grant=4'b0010.
